lfsr_rng: RTL and testbench

LFSR_RNG -- requirements
Module: lfsr_rng

---
 rtl/lfsr_rng_pkg.sv | 49 ++++
 rtl/lfsr_rng_core.sv | 52 +++++
 rtl/lfsr_rng.sv | 73 +++++++
 tb/tb_lfsr_rng.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: FSM state type and default XNOR tap masks for 4..32-bit LFSRs
package lfsr_rng_pkg;

  typedef enum logic {IDLE, ARMED} state_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  function automatic logic [31:0] pos(input int k);
    return 32'd1 << (k - 1);
  endfunction

  // Maximal-length XNOR tap sets, bit i set means state bit i feeds the XNOR
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      4:  return pos(4)  | pos(3);
      5:  return pos(5)  | pos(3);
      6:  return pos(6)  | pos(5);
      7:  return pos(7)  | pos(6);
      8:  return pos(8)  | pos(6)  | pos(5)  | pos(4);
      9:  return pos(9)  | pos(5);
      10: return pos(10) | pos(7);
      11: return pos(11) | pos(9);
      12: return pos(12) | pos(6)  | pos(4)  | pos(1);
      13: return pos(13) | pos(4)  | pos(3)  | pos(1);
      14: return pos(14) | pos(5)  | pos(3)  | pos(1);
      15: return pos(15) | pos(14);
      16: return pos(16) | pos(15) | pos(13) | pos(4);
      17: return pos(17) | pos(14);
      18: return pos(18) | pos(11);
      19: return pos(19) | pos(6)  | pos(2)  | pos(1);
      20: return pos(20) | pos(17);
      21: return pos(21) | pos(19);
      22: return pos(22) | pos(21);
      23: return pos(23) | pos(18);
      24: return pos(24) | pos(23) | pos(22) | pos(17);
      25: return pos(25) | pos(22);
      26: return pos(26) | pos(6)  | pos(2)  | pos(1);
      27: return pos(27) | pos(5)  | pos(2)  | pos(1);
      28: return pos(28) | pos(25);
      29: return pos(29) | pos(27);
      30: return pos(30) | pos(6)  | pos(4)  | pos(1);
      31: return pos(31) | pos(28);
      32: return pos(32) | pos(22) | pos(2)  | pos(1);
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rng_core.sv
// lfsr_core: XNOR LFSR register, saturating step counter, seed load; LFSR_RNG_LOCKUP_EN clears the all-ones lockup state
module lfsr_core
  import lfsr_rng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'h88)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             step_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed_in;
  logic [CW-1:0]    cnt;
  logic             feed;
  logic             lock;

  assign feed = ~^(state & TAPS);

`ifdef LFSR_RNG_LOCKUP_EN
  assign lock    = &state;
  assign seed_in = (&seed) ? '0 : seed;
`else
  assign lock    = 1'b0;
  assign seed_in = seed;
`endif

  // Seed load wins over stepping; the step counter saturates at WIDTH
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= '0;
      cnt   <= '0;
    end else if (seed_load) begin
      state <= seed_in;
      cnt   <= '0;
    end else if (step_en) begin
      state <= lock ? '0 : {state[WIDTH-2:0], feed};
      cnt   <= (cnt == CW'(WIDTH)) ? cnt : cnt + 1'b1;
    end
  end

  assign rnd       = state;
  assign rnd_valid = (cnt == CW'(WIDTH));

endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: LFSR random source plus random-delay countdown with one-cycle fire pulse; optional LFSR_RNG_LOCKUP_EN
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'h88),
  parameter int RANGE_BITS = 4,
  parameter int MIN_DELAY = 1000,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               step_en,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   rnd,
  output logic               rnd_valid,
  output logic               busy,
  output logic [DELAY_W-1:0] count,
  output logic               fire
);

  state_t             state;
  logic [DELAY_W-1:0] delay;

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk       (clk),
    .res_n     (res_n),
    .step_en   (step_en),
    .seed_load (seed_load),
    .seed      (seed),
    .rnd       (rnd),
    .rnd_valid (rnd_valid)
  );

  assign delay = DELAY_W'(MIN_DELAY) + DELAY_W'(rnd[RANGE_BITS-1:0]);

  // Countdown FSM: arm on start, abort on stop, pulse fire once after reaching zero
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= IDLE;
      count <= '0;
      fire  <= 1'b0;
    end else begin
      fire <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= ARMED;
            count <= delay;
          end
        end
        ARMED: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
          end else if (count == '0) begin
            state <= IDLE;
            fire  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ARMED);

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed table-driven bench for lfsr_rng; lockup expectations follow LFSR_RNG_LOCKUP_EN
module tb_lfsr_rng;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        step_en = 1'b0;
  logic        seed_load = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  rnd;
  logic        rnd_valid;
  logic        busy;
  logic [15:0] count;
  logic        fire;

  int checks = 0;
  int errors = 0;

  lfsr_rng #(.MIN_DELAY(3), .RANGE_BITS(2)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .step_en   (step_en),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .stop      (stop),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .count     (count),
    .fire      (fire)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       res_n;
    logic       step_en;
    logic       seed_load;
    logic [7:0] seed;
    logic [7:0] exp_rnd;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic go(input logic r, input logic se, input logic sl, input logic [7:0] sd,
                    input logic st, input logic sp);
    res_n = r; step_en = se; seed_load = sl; seed = sd; start = st; stop = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    go(1, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic cd(input string name, input logic b, input logic [15:0] c, input logic f);
    chk({name, " busy"}, 32'(busy), 32'(b));
    chk({name, " count"}, 32'(count), 32'(c));
    chk({name, " fire"}, 32'(fire), 32'(f));
  endtask

  task automatic arm();
    go(0, 0, 0, 8'h00, 0, 0);
    go(1, 1, 0, 8'h00, 0, 0);
    chk("arm rnd", 32'(rnd), 32'h01);
    go(1, 0, 0, 8'h00, 1, 0);
    cd("arm t+1", 1, 16'd4, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 8'h00, 8'h00, 0};
    vecs[1]  = '{1, 1, 0, 8'h00, 8'h01, 0};
    vecs[2]  = '{1, 1, 0, 8'h00, 8'h03, 0};
    vecs[3]  = '{1, 1, 0, 8'h00, 8'h07, 0};
    vecs[4]  = '{1, 1, 0, 8'h00, 8'h0F, 0};
    vecs[5]  = '{1, 1, 0, 8'h00, 8'h1E, 0};
    vecs[6]  = '{1, 1, 0, 8'h00, 8'h3C, 0};
    vecs[7]  = '{1, 1, 0, 8'h00, 8'h78, 0};
    vecs[8]  = '{1, 1, 0, 8'h00, 8'hF0, 1};
    vecs[9]  = '{1, 1, 0, 8'h00, 8'hE0, 1};
    vecs[10] = '{1, 1, 0, 8'h00, 8'hC0, 1};
    vecs[11] = '{1, 1, 0, 8'h00, 8'h80, 1};
    vecs[12] = '{1, 1, 0, 8'h00, 8'h00, 1};
    vecs[13] = '{1, 1, 0, 8'h00, 8'h01, 1};
    vecs[14] = '{1, 0, 0, 8'h00, 8'h01, 1};
    vecs[15] = '{1, 1, 1, 8'h5A, 8'h5A, 0};
    vecs[16] = '{1, 1, 0, 8'h00, 8'hB4, 0};

    for (int i = 0; i < 17; i++) begin
      go(vecs[i].res_n, vecs[i].step_en, vecs[i].seed_load, vecs[i].seed, 0, 0);
      chk($sformatf("vec%0d rnd", i), 32'(rnd), 32'(vecs[i].exp_rnd));
      chk($sformatf("vec%0d valid", i), 32'(rnd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
    end

    arm();
    go(1, 0, 0, 8'h00, 1, 0);
    cd("expire t+2", 1, 16'd3, 0);
    go(1, 1, 0, 8'h00, 0, 0);
    cd("expire t+3", 1, 16'd2, 0);
    idle();
    cd("expire t+4", 1, 16'd1, 0);
    idle();
    cd("expire t+5", 1, 16'd0, 0);
    idle();
    cd("expire t+6", 0, 16'd0, 1);
    idle();
    cd("expire t+7", 0, 16'd0, 0);

    arm();
    idle();
    cd("stop t+2", 1, 16'd3, 0);
    idle();
    cd("stop t+3", 1, 16'd2, 0);
    go(1, 0, 0, 8'h00, 0, 1);
    cd("stop t+4", 0, 16'd0, 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("stop nofire", 32'(fire), 32'd0);
    end

    arm();
    for (int i = 0; i < 4; i++) idle();
    cd("stopexp t+5", 1, 16'd0, 0);
    go(1, 0, 0, 8'h00, 0, 1);
    cd("stopexp t+6", 0, 16'd0, 0);
    idle();
    chk("stopexp t+7 fire", 32'(fire), 32'd0);

    go(1, 0, 0, 8'h00, 1, 1);
    cd("start+stop idle", 0, 16'd0, 0);

    arm();
    idle();
    cd("rst t+2", 1, 16'd3, 0);
    go(0, 1, 0, 8'h00, 1, 0);
    cd("rst t+3", 0, 16'd0, 0);
    chk("rst t+3 rnd", 32'(rnd), 32'd0);
    chk("rst t+3 valid", 32'(rnd_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("rst nofire", 32'(fire), 32'd0);
    end

    go(1, 0, 1, 8'hFF, 0, 0);
`ifdef LFSR_RNG_LOCKUP_EN
    chk("lock seed", 32'(rnd), 32'h00);
    go(1, 0, 0, 8'h00, 0, 0);
    go(1, 1, 0, 8'h00, 0, 0);
    chk("lock step1", 32'(rnd), 32'h01);
`else
    chk("lock seed", 32'(rnd), 32'hFF);
    go(1, 1, 0, 8'h00, 0, 0);
    chk("lock step1", 32'(rnd), 32'hFF);
    go(1, 1, 0, 8'h00, 0, 0);
    chk("lock step2", 32'(rnd), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
